palette_arbiter: RTL and testbench

PALETTE_ARBITER -- requirements
Module: palette_arbiter

---
 rtl/palette_arbiter.sv | 115 +++++++++++
 tb/tb_palette_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_arbiter.sv
// rtl/palette_arbiter.sv - palette RAM arbiter: pixel reads during video, queued host writes committed in blanking
module palette_arbiter #(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 24,
   parameter int FIFO_DEPTH = 4,
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              rfr_clk,
   input  logic              reset_n,
   input  logic              video_on,
   input  logic              frame_start,
   input  logic              frame_lock,
   input  logic [ADDR_W-1:0] pix_addr,
   output logic [DATA_W-1:0] pix_data,
   input  logic              host_wr_valid,
   output logic              host_wr_ready,
   input  logic [ADDR_W-1:0] host_wr_addr,
   input  logic [DATA_W-1:0] host_wr_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [CNT_W-1:0]  pending_cnt,
   output logic              overflow_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ACTIVE,
      BLANK_WAIT,
      BLANK_DRAIN
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              ready_en;
   logic              pix_vld;
   logic              push;
   logic              pop;

   // ready_en keeps the host stalled until the first clock after reset release
   assign host_wr_ready = ready_en && (pending_cnt != FULL_CNT);
   assign push          = host_wr_valid && host_wr_ready;
   assign pop           = (state == BLANK_DRAIN) && !video_on && (pending_cnt != '0);

   assign ram_we    = pop;
   assign ram_addr  = pop ? fifo_addr[rd_ptr] : pix_addr;
   assign ram_wdata = fifo_data[rd_ptr];

   always_ff @(posedge rfr_clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ACTIVE;
      end else if (video_on) begin
         state <= ACTIVE;
      end else begin
         case (state)
            // a frame_start coinciding with the first blank cycle must not be missed
            ACTIVE:      state <= (frame_lock && !frame_start) ? BLANK_WAIT : BLANK_DRAIN;
            BLANK_WAIT:  state <= frame_start ? BLANK_DRAIN : BLANK_WAIT;
            BLANK_DRAIN: state <= BLANK_DRAIN;
            default:     state <= ACTIVE;
         endcase
      end
   end

   always_ff @(posedge rfr_clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= host_wr_addr;
         fifo_data[wr_ptr] <= host_wr_data;
      end
   end

   always_ff @(posedge rfr_clk or negedge reset_n) begin
      if (!reset_n) begin
         ready_en     <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         pending_cnt  <= '0;
         overflow_err <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   pending_cnt <= pending_cnt + CNT_W'(1);
            2'b01:   pending_cnt <= pending_cnt - CNT_W'(1);
            default: pending_cnt <= pending_cnt;
         endcase
         if (host_wr_valid && (pending_cnt == FULL_CNT)) begin
            overflow_err <= 1'b1;
         end
      end
   end

   // write cycles are masked so a RAM write never leaks onto the RGB output
   always_ff @(posedge rfr_clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_vld  <= 1'b0;
         pix_data <= '0;
      end else begin
         pix_vld  <= video_on && !ram_we;
         pix_data <= pix_vld ? ram_rdata : '0;
      end
   end

endmodule

// File: tb/tb_palette_arbiter.sv
// tb/tb_palette_arbiter.sv - scoreboard bench for palette_arbiter
module tb_palette_arbiter;

   localparam int AW = 6;
   localparam int DW = 24;

   logic          rfr_clk = 1'b0;
   logic          reset_n;
   logic          video_on;
   logic          frame_start;
   logic          frame_lock;
   logic [AW-1:0] pix_addr;
   logic [DW-1:0] pix_data;
   logic          host_wr_valid;
   logic          host_wr_ready;
   logic [AW-1:0] host_wr_addr;
   logic [DW-1:0] host_wr_data;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic [DW-1:0] ram_rdata;
   logic [2:0]    pending_cnt;
   logic          overflow_err;

   palette_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
      .rfr_clk(rfr_clk), .reset_n(reset_n), .video_on(video_on),
      .frame_start(frame_start), .frame_lock(frame_lock),
      .pix_addr(pix_addr), .pix_data(pix_data),
      .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
      .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .ram_rdata(ram_rdata), .pending_cnt(pending_cnt), .overflow_err(overflow_err)
   );

   always #5 rfr_clk = ~rfr_clk;

   logic [DW-1:0] ram_mem [64];
   always @(posedge rfr_clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
   end

   typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
   typedef struct {int due; logic [DW-1:0] v;} px_t;
   wr_t sb_q[$];
   px_t pq[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int we_count = 0;
   int we_first = -1;
   int we_last = -1;

   always @(posedge rfr_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge rfr_clk);
         #1;
      end
   endtask

   always @(negedge rfr_clk) begin
      wr_t e;
      px_t p;
      if (ram_we) begin
         we_count++;
         if (we_first < 0) we_first = cyc;
         we_last = cyc;
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", ram_addr, ram_wdata);
         end else begin
            e = sb_q.pop_front();
            chk("wr_addr", 32'(ram_addr), 32'(e.a));
            chk("wr_data", 32'(ram_wdata), 32'(e.d));
         end
      end
      if (video_on) chk("we_in_video", 32'(ram_we), 32'd0);
      if (!ram_we) chk("ram_addr_pix", 32'(ram_addr), 32'(pix_addr));
      if (pq.size() != 0 && pq[0].due == cyc) begin
         p = pq.pop_front();
         chk("pix_data", 32'(pix_data), 32'(p.v));
      end
   end

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n;
      wr_t e;
      n = 0;
      host_wr_valid = 1'b1;
      host_wr_addr  = a;
      host_wr_data  = d;
      while (!host_wr_ready && n < 20) begin
         tick(1);
         n++;
      end
      chk("push_ready", 32'(host_wr_ready), 32'd1);
      if (host_wr_ready) begin
         e.a = a;
         e.d = d;
         sb_q.push_back(e);
      end
      tick(1);
      host_wr_valid = 1'b0;
   endtask

   task automatic pix_cycle(input logic [AW-1:0] a, input logic [DW-1:0] v);
      px_t p;
      pix_addr = a;
      p.due = cyc + 2;
      p.v = v;
      pq.push_back(p);
      tick(1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; video_on = 1'b0; frame_start = 1'b0; frame_lock = 1'b0;
      pix_addr = '0; host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
      tick(2);
      @(negedge rfr_clk);
      chk("rst_ready", 32'(host_wr_ready), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_pending", 32'(pending_cnt), 32'd0);
      chk("rst_pix", 32'(pix_data), 32'd0);
      chk("rst_ovf", 32'(overflow_err), 32'd0);
      tick(1);
      reset_n = 1'b1;
      tick(1);
      @(negedge rfr_clk);
      chk("ready_after_rst", 32'(host_wr_ready), 32'd1);

      // unlocked blank: writes drain back to back
      tick(1);
      push(6'd5, 24'hAAAAAA);
      push(6'd6, 24'hBBBBBB);
      push(6'd7, 24'hCCCCCC);
      tick(3);
      @(negedge rfr_clk);
      chk("t1_pending", 32'(pending_cnt), 32'd0);
      chk("t1_we_count", 32'(we_count), 32'd3);
      chk("t1_consecutive", 32'(we_last - we_first), 32'd2);

      // video: writes held, fifo fills, overflow, no forwarding
      tick(1);
      video_on = 1'b1;
      tick(1);
      repeat (3) pix_cycle(6'd5, 24'hAAAAAA);
      push(6'd5, 24'h111111);
      push(6'd5, 24'h222222);
      push(6'd9, 24'h333333);
      push(6'd10, 24'h444444);
      @(negedge rfr_clk);
      chk("full_ready", 32'(host_wr_ready), 32'd0);
      chk("full_pending", 32'(pending_cnt), 32'd4);
      tick(1);
      host_wr_valid = 1'b1; host_wr_addr = 6'd11; host_wr_data = 24'h555555;
      tick(2);
      host_wr_valid = 1'b0;
      @(negedge rfr_clk);
      chk("ovf_set", 32'(overflow_err), 32'd1);
      chk("ovf_pending", 32'(pending_cnt), 32'd4);
      tick(1);
      repeat (2) pix_cycle(6'd5, 24'hAAAAAA);
      video_on = 1'b0;
      repeat (8) pix_cycle(6'd5, 24'h000000);
      @(negedge rfr_clk);
      chk("t2_pending", 32'(pending_cnt), 32'd0);
      chk("t2_ovf_sticky", 32'(overflow_err), 32'd1);
      tick(1);
      video_on = 1'b1;
      pix_cycle(6'd5, 24'h222222);
      pix_cycle(6'd9, 24'h333333);
      pix_cycle(6'd10, 24'h444444);
      tick(2);

      // frame lock: hblank holds, vblank after frame_start commits
      frame_lock = 1'b1;
      push(6'd20, 24'hFF0000);
      push(6'd21, 24'h00FF00);
      video_on = 1'b0;
      tick(5);
      @(negedge rfr_clk);
      chk("hblank_pending", 32'(pending_cnt), 32'd2);
      chk("hblank_we_count", 32'(we_count), 32'd7);
      tick(1);
      video_on = 1'b1;
      tick(2);
      video_on = 1'b0;
      tick(1);
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      tick(4);
      @(negedge rfr_clk);
      chk("vblank_pending", 32'(pending_cnt), 32'd0);
      chk("vblank_we_count", 32'(we_count), 32'd9);
      tick(1);
      video_on = 1'b1;
      pix_cycle(6'd20, 24'hFF0000);
      pix_cycle(6'd21, 24'h00FF00);
      tick(2);

      // video resumes mid-drain
      frame_lock = 1'b0;
      push(6'd30, 24'h300000);
      push(6'd31, 24'h310000);
      push(6'd32, 24'h320000);
      push(6'd33, 24'h330000);
      video_on = 1'b0;
      tick(3);
      video_on = 1'b1;
      @(negedge rfr_clk);
      chk("resume_we", 32'(ram_we), 32'd0);
      chk("resume_pending", 32'(pending_cnt), 32'd2);
      tick(3);
      video_on = 1'b0;
      tick(5);
      @(negedge rfr_clk);
      chk("t4_pending", 32'(pending_cnt), 32'd0);
      chk("t4_we_count", 32'(we_count), 32'd13);
      chk("t4_ovf_sticky", 32'(overflow_err), 32'd1);

      // reset mid-drain
      tick(1);
      video_on = 1'b1;
      tick(1);
      push(6'd40, 24'h400000);
      push(6'd41, 24'h410000);
      push(6'd42, 24'h420000);
      push(6'd43, 24'h430000);
      video_on = 1'b0;
      tick(2);
      reset_n = 1'b0;
      sb_q.delete();
      pq.delete();
      @(negedge rfr_clk);
      chk("mid_rst_pending", 32'(pending_cnt), 32'd0);
      chk("mid_rst_pix", 32'(pix_data), 32'd0);
      chk("mid_rst_ovf", 32'(overflow_err), 32'd0);
      chk("mid_rst_we", 32'(ram_we), 32'd0);
      chk("mid_rst_ready", 32'(host_wr_ready), 32'd0);
      tick(2);
      reset_n = 1'b1;
      tick(10);
      @(negedge rfr_clk);
      chk("post_rst_we_count", 32'(we_count), 32'd14);
      chk("post_rst_pending", 32'(pending_cnt), 32'd0);
      chk("post_rst_ready", 32'(host_wr_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
